// File: rtl/aes_ctrl_if.sv
// Frame, AES-core and read-back signals shared by the I2C slave, the AES
// sequencer and the AES-128 core. clk and reset stay plain ports.
interface aes_ctrl_if;
    logic [263:0] frame_in;
    logic         frame_valid;
    logic [127:0] aes_key;
    logic [127:0] aes_din;
    logic         aes_mode;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_dout;
    logic [127:0] result;
    logic         result_valid;
    logic         result_ack;
    logic [7:0]   status;

    modport slave (
        input  frame_in, frame_valid, aes_done, aes_dout, result_ack,
        output aes_key, aes_din, aes_mode, aes_start, result, result_valid, status
    );

    modport master (
        output frame_in, frame_valid, aes_done, aes_dout, result_ack,
        input  aes_key, aes_din, aes_mode, aes_start, result, result_valid, status
    );
endinterface

// File: rtl/aes_ctrl.sv
// Sequencer between the I2C frame receiver and the AES-128 core: decodes the
// command byte, launches one core operation with a timeout, holds the result.
module aes_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    aes_ctrl_if.slave  bus
);

    localparam int              CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic          key_loaded_r, key_loaded_s;
    logic [127:0]  key_r, key_s;
    logic [127:0]  din_r, din_s;
    logic          mode_r, mode_s;
    logic          start_r, start_s;
    logic [127:0]  result_r, result_s;
    logic          rv_r, rv_s;
    logic          overrun_r, overrun_s;
    logic          timeout_r, timeout_s;
    logic          nokey_r, nokey_s;
    logic          badcmd_r, badcmd_s;
    logic [7:0]    status_r, status_s;
    logic          busy_s;

    logic [127:0]  frame_key_s;
    logic [127:0]  frame_blk_s;
    logic [7:0]    frame_cmd_s;

    assign frame_key_s = bus.frame_in[263:136];
    assign frame_blk_s = bus.frame_in[135:8];
    assign frame_cmd_s = bus.frame_in[7:0];

    // Next-state and next-output decode for the sequencer.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        key_loaded_s = key_loaded_r;
        key_s        = key_r;
        din_s        = din_r;
        mode_s       = mode_r;
        start_s      = 1'b0;
        result_s     = result_r;
        rv_s         = rv_r;
        overrun_s    = overrun_r;
        timeout_s    = timeout_r;
        nokey_s      = nokey_r;
        badcmd_s     = badcmd_r;

        case (state_r)
            S_IDLE, S_HOLD: begin
                if (bus.frame_valid) begin
                    // A new frame wins over a coincident ack and drops any unread result.
                    overrun_s = 1'b0;
                    timeout_s = 1'b0;
                    nokey_s   = 1'b0;
                    badcmd_s  = 1'b0;
                    rv_s      = 1'b0;
                    if (frame_cmd_s[7:2] != 6'd0) begin
                        badcmd_s = 1'b1;
                        state_s  = S_IDLE;
                    end else if (!frame_cmd_s[1] && !key_loaded_r) begin
                        nokey_s = 1'b1;
                        state_s = S_IDLE;
                    end else begin
                        if (frame_cmd_s[1]) begin
                            key_s        = frame_key_s;
                            key_loaded_s = 1'b1;
                        end else begin
                            key_s = key_r;
                        end
                        din_s   = frame_blk_s;
                        mode_s  = frame_cmd_s[0];
                        start_s = 1'b1;
                        cnt_s   = {CW{1'b0}};
                        state_s = S_START;
                    end
                end else if ((state_r == S_HOLD) && bus.result_ack) begin
                    rv_s    = 1'b0;
                    state_s = S_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            S_START: begin
                cnt_s   = {CW{1'b0}};
                state_s = S_WAIT;
                if (bus.frame_valid) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
            end
            S_WAIT: begin
                if (bus.frame_valid) begin
                    overrun_s = 1'b1;
                end else begin
                    overrun_s = overrun_r;
                end
                if (bus.aes_done) begin
                    result_s = bus.aes_dout;
                    rv_s     = 1'b1;
                    state_s  = S_HOLD;
                end else if (cnt_r == CNT_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = S_IDLE;
                end else begin
                    cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase

        busy_s   = (state_s == S_START) || (state_s == S_WAIT);
        status_s = {busy_s, rv_s, 2'b00, overrun_s, timeout_s, nokey_s, badcmd_s};
    end

    // State and output registers; status is registered from next-cycle values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_IDLE;
            cnt_r        <= {CW{1'b0}};
            key_loaded_r <= 1'b0;
            key_r        <= 128'd0;
            din_r        <= 128'd0;
            mode_r       <= 1'b0;
            start_r      <= 1'b0;
            result_r     <= 128'd0;
            rv_r         <= 1'b0;
            overrun_r    <= 1'b0;
            timeout_r    <= 1'b0;
            nokey_r      <= 1'b0;
            badcmd_r     <= 1'b0;
            status_r     <= 8'd0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            key_loaded_r <= key_loaded_s;
            key_r        <= key_s;
            din_r        <= din_s;
            mode_r       <= mode_s;
            start_r      <= start_s;
            result_r     <= result_s;
            rv_r         <= rv_s;
            overrun_r    <= overrun_s;
            timeout_r    <= timeout_s;
            nokey_r      <= nokey_s;
            badcmd_r     <= badcmd_s;
            status_r     <= status_s;
        end
    end

    assign bus.aes_key      = key_r;
    assign bus.aes_din      = din_r;
    assign bus.aes_mode     = mode_r;
    assign bus.aes_start    = start_r;
    assign bus.result       = result_r;
    assign bus.result_valid = rv_r;
    assign bus.status       = status_r;

endmodule

// File: tb/tb_aes_ctrl.sv
// Directed plus randomized bench for aes_ctrl with a transaction-level model
// of the command decode, stored key and expected core result.
module tb_aes_ctrl;

    localparam int TO = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    aes_ctrl_if bus ();

    aes_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total   = 0;
    int bad     = 0;
    int n_start = 0;

    // Counts start pulses seen by the core.
    always @(posedge clk) begin
        if (bus.aes_start === 1'b1) n_start <= n_start + 1;
    end

    // Reference model: what the core should currently be holding.
    logic [127:0] m_key;
    logic [127:0] m_din;
    logic         m_mode;
    logic         m_loaded;

    localparam logic [127:0] K1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] B1 = 128'h0123456789ABCDEF0123456789ABCDEF;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key    = 128'd0;
        m_din    = 128'd0;
        m_mode   = 1'b0;
        m_loaded = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_key"}, bus.aes_key, 128'd0);
        chk({tag, "_din"}, bus.aes_din, 128'd0);
        chk1({tag, "_mode"}, bus.aes_mode, 1'b0);
        chk1({tag, "_start"}, bus.aes_start, 1'b0);
        chk({tag, "_result"}, bus.result, 128'd0);
        chk1({tag, "_rv"}, bus.result_valid, 1'b0);
        chk8({tag, "_status"}, bus.status, 8'h00);
    endtask

    // Presents a frame in IDLE/HOLD and checks the decode one cycle later.
    task automatic frame(input string tag, input logic [127:0] k, input logic [127:0] b,
                         input logic [7:0] c, input logic ack, output logic acc);
        logic [7:0] exp_st;
        if (c[7:2] != 6'd0) begin
            exp_st = 8'h01;
            acc    = 1'b0;
        end else if (!c[1] && !m_loaded) begin
            exp_st = 8'h02;
            acc    = 1'b0;
        end else begin
            if (c[1]) begin
                m_key    = k;
                m_loaded = 1'b1;
            end
            m_din  = b;
            m_mode = c[0];
            exp_st = 8'h80;
            acc    = 1'b1;
        end
        bus.frame_in    = {k, b, c};
        bus.frame_valid = 1'b1;
        bus.result_ack  = ack;
        tick();
        bus.frame_valid = 1'b0;
        bus.result_ack  = 1'b0;
        chk8({tag, "_status"}, bus.status, exp_st);
        chk1({tag, "_start"}, bus.aes_start, acc);
        chk({tag, "_key"}, bus.aes_key, m_key);
        chk({tag, "_din"}, bus.aes_din, m_din);
        chk1({tag, "_mode"}, bus.aes_mode, m_mode);
        chk1({tag, "_rv"}, bus.result_valid, 1'b0);
    endtask

    // Core stub: done pulse d cycles after the start cycle.
    task automatic respond(input string tag, input int d, input logic [127:0] dout,
                           input logic [7:0] exp_st);
        repeat (d) tick();
        chk1({tag, "_rv_before"}, bus.result_valid, 1'b0);
        chk1({tag, "_busy_before"}, bus.status[7], 1'b1);
        bus.aes_done = 1'b1;
        bus.aes_dout = dout;
        tick();
        bus.aes_done = 1'b0;
        bus.aes_dout = 128'd0;
        chk({tag, "_result"}, bus.result, dout);
        chk1({tag, "_rv"}, bus.result_valid, 1'b1);
        chk8({tag, "_status"}, bus.status, exp_st);
    endtask

    task automatic ack_result(input string tag, input logic [127:0] exp_res, input logic [7:0] exp_st);
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        chk1({tag, "_rv"}, bus.result_valid, 1'b0);
        chk({tag, "_result"}, bus.result, exp_res);
        chk8({tag, "_status"}, bus.status, exp_st);
    endtask

    initial begin
        logic         acc;
        int           s0;
        logic [127:0] k, b, exp_res;
        logic [7:0]   c;

        bus.frame_in    = 264'd0;
        bus.frame_valid = 1'b0;
        bus.aes_done    = 1'b0;
        bus.aes_dout    = 128'd0;
        bus.result_ack  = 1'b0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Errors straight after reset
        frame("nokey", K1, B1, 8'h00, 1'b0, acc);
        frame("badcmd", K1, B1, 8'h12, 1'b0, acc);
        tick();
        chk("no_start_on_error", 128'(n_start), 128'd0);

        // Normal encrypt
        s0 = n_start;
        frame("enc", K1, B1, 8'h02, 1'b0, acc);
        chk("enc_key_const", bus.aes_key, K1);
        respond("enc", 11, ~B1, 8'h40);
        chk("enc_result_const", bus.result, 128'hFEDCBA9876543210FEDCBA9876543210);
        chk("enc_one_start", 128'(n_start - s0), 128'd1);

        // Key reuse and decrypt from HOLD
        b = 128'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F;
        frame("dec", 128'd0, b, 8'h01, 1'b0, acc);
        chk("dec_key_kept", bus.aes_key, K1);
        respond("dec", 5, ~b, 8'h40);
        ack_result("dec_ack", ~b, 8'h00);

        // Timeout, then a fresh frame clears it; done on the last WAIT cycle
        frame("to", 128'd0, B1, 8'h00, 1'b0, acc);
        repeat (TO) tick();
        chk8("to_cycle65", bus.status, 8'h80);
        tick();
        chk8("to_cycle66", bus.status, 8'h04);
        chk1("to_rv", bus.result_valid, 1'b0);
        frame("after_to", 128'd0, ~B1, 8'h00, 1'b0, acc);
        respond("last_wait", TO, B1 ^ K1, 8'h40);
        ack_result("last_wait_ack", B1 ^ K1, 8'h00);

        // Overrun during WAIT
        s0 = n_start;
        k = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        b = 128'hCAFE_F00D_DEAD_BEEF_0BAD_C0DE_1357_9BDF;
        frame("ovr", k, b, 8'h02, 1'b0, acc);
        repeat (3) tick();
        bus.frame_in    = {~k, ~b, 8'h02};
        bus.frame_valid = 1'b1;
        tick();
        bus.frame_valid = 1'b0;
        chk8("ovr_status", bus.status, 8'h88);
        chk("ovr_din_kept", bus.aes_din, b);
        chk("ovr_key_kept", bus.aes_key, k);
        respond("ovr", 6, ~b, 8'h48);
        tick();
        chk("ovr_one_start", 128'(n_start - s0), 128'd1);

        // Frame and ack together in HOLD
        frame("coll", 128'd0, B1, 8'h03, 1'b1, acc);

        // Reset during WAIT
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check_all_zero("rst_wait");
        tick();
        tick();
        reset = 1'b1;
        model_reset();
        s0 = n_start;
        bus.aes_done = 1'b1;
        bus.aes_dout = ~B1;
        tick();
        bus.aes_done = 1'b0;
        tick();
        check_all_zero("late_done");
        chk("late_no_start", 128'(n_start - s0), 128'd0);

        // Randomized frames against the model
        for (int i = 0; i < 30; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 7) == 0) c = 8'($urandom_range(4, 255));
            else c = 8'($urandom_range(0, 3));
            frame("rnd", k, b, c, 1'b0, acc);
            if (acc) begin
                if ($urandom_range(0, 9) == 0) begin
                    repeat (TO + 1) tick();
                    chk8("rnd_timeout", bus.status, 8'h04);
                end else begin
                    exp_res = m_din ^ m_key ^ {128{m_mode}};
                    respond("rnd", int'($urandom_range(1, 20)), exp_res, 8'h40);
                    if ($urandom_range(0, 1) == 1) ack_result("rnd_ack", exp_res, 8'h00);
                end
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
